// File: rtl/oam_dma_if.sv
// CPU-bus and PPU-register-port signals shared by the sprite DMA and its surroundings.
// No latency of its own; it only carries wires.
// Flow control is the cpu_ce / cpu_rdy stall handshake carried here.
interface oam_dma_if;
  // CPU side
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_we;
  logic        cpu_rdy;
  // DMA ownership of the CPU bus
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_rdata;
  // PPU register port
  logic        ppu_cs_n;
  logic        ppu_we;
  logic [2:0]  ppu_reg_addr;
  logic [7:0]  ppu_wdata;

  // The DMA engine itself
  modport slave (
    input  cpu_ce, cpu_addr, cpu_data, cpu_we, dma_rdata,
    output cpu_rdy, dma_active, dma_addr, dma_rd,
    output ppu_cs_n, ppu_we, ppu_reg_addr, ppu_wdata
  );

  // The CPU / bus fabric / PPU side that talks to the DMA engine
  modport master (
    output cpu_ce, cpu_addr, cpu_data, cpu_we, dma_rdata,
    input  cpu_rdy, dma_active, dma_addr, dma_rd,
    input  ppu_cs_n, ppu_we, ppu_reg_addr, ppu_wdata
  );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA for $4014: halts the CPU and copies one 256-byte CPU page into OAMDATA.
// Latency: 513 CPU cycles of stall, or 514 when an extra alignment cycle is needed.
// Backpressure: the CPU is stalled through cpu_rdy; each PPU write completes within one CPU cycle.
module oam_dma #(
  parameter logic [15:0] DMA_REG = 16'h4014,
  parameter logic [2:0]  OAM_REG = 3'd4,
  parameter int unsigned CS_LOW  = 2
) (
  input  logic     clk,
  input  logic     reset,
  oam_dma_if.slave bus
);

  // Counter just wide enough to hold CS_LOW-1.
  localparam int CNT_W = (CS_LOW < 2) ? 1 : $clog2(CS_LOW);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CS_LOW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             parity;
  logic [7:0]       page;
  logic [7:0]       idx;
  logic [7:0]       rd_idx;
  logic [CNT_W-1:0] cs_cnt;

  logic             cpu_rdy_q;
  logic             dma_active_q;
  logic [15:0]      dma_addr_q;
  logic             dma_rd_q;
  logic [7:0]       ppu_wdata_q;
  logic             ppu_cs_n_q;
  logic             ppu_we_q;

  // one-clk control strobes from the next-state logic
  logic trig;
  logic rd_start;
  logic rd_done;
  logic byte_adv;
  logic finish;

  logic dma_hit;
  assign dma_hit = bus.cpu_ce && bus.cpu_we && (bus.cpu_addr == DMA_REG);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and control strobes; every CPU-side step waits for cpu_ce.
  always_comb begin
    state_nxt = state;
    trig      = 1'b0;
    rd_start  = 1'b0;
    rd_done   = 1'b0;
    byte_adv  = 1'b0;
    finish    = 1'b0;
    rd_idx    = idx;
    unique case (state)
      S_IDLE: begin
        // triggers outside IDLE are simply never looked at
        if (dma_hit) begin
          trig      = 1'b1;
          state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        if (bus.cpu_ce) begin
          if (parity) begin
            state_nxt = S_ALIGN;
          end else begin
            rd_start  = 1'b1;
            state_nxt = S_READ;
          end
        end
      end
      S_ALIGN: begin
        if (bus.cpu_ce) begin
          rd_start  = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (bus.cpu_ce) begin
          rd_done   = 1'b1;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.cpu_ce) begin
          byte_adv = 1'b1;
          if (idx == 8'hFF) begin
            finish    = 1'b1;
            state_nxt = S_DONE;
          end else begin
            rd_start  = 1'b1;
            rd_idx    = idx + 8'd1;
            state_nxt = S_READ;
          end
        end
      end
      S_DONE: begin
        // CPU was already released on entry; this just settles back to IDLE
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // CPU-cycle parity, source page and byte index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
    end else begin
      if (bus.cpu_ce) begin
        parity <= ~parity;
      end
      if (trig) begin
        page <= bus.cpu_data;
        idx  <= 8'h00;
      end else if (byte_adv) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // CPU stall / bus ownership and the read request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      dma_addr_q   <= 16'h0000;
      dma_rd_q     <= 1'b0;
    end else begin
      if (trig) begin
        cpu_rdy_q    <= 1'b0;
        dma_active_q <= 1'b1;
      end else if (finish) begin
        cpu_rdy_q    <= 1'b1;
        dma_active_q <= 1'b0;
      end
      if (rd_start) begin
        // page $FF ends at $FFFF: idx is 8 bits so nothing carries into the page
        dma_addr_q <= {page, rd_idx};
        dma_rd_q   <= 1'b1;
      end else if (rd_done) begin
        dma_rd_q <= 1'b0;
      end
    end
  end

  // OAMDATA write strobe: one cs_n low pulse of CS_LOW clks per byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ppu_wdata_q <= 8'h00;
      ppu_cs_n_q  <= 1'b1;
      ppu_we_q    <= 1'b0;
      cs_cnt      <= '0;
    end else begin
      if (rd_done) begin
        ppu_wdata_q <= bus.dma_rdata;
        ppu_cs_n_q  <= 1'b0;
        ppu_we_q    <= 1'b1;
        cs_cnt      <= CNT_LOAD;
      end else if (byte_adv) begin
        // never let a strobe straddle into the next read cycle
        ppu_cs_n_q <= 1'b1;
        ppu_we_q   <= 1'b0;
      end else if (state == S_WRITE && !ppu_cs_n_q) begin
        if (cs_cnt != '0) begin
          cs_cnt <= cs_cnt - 1'b1;
        end else begin
          ppu_cs_n_q <= 1'b1;
          ppu_we_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.cpu_rdy      = cpu_rdy_q;
  assign bus.dma_active   = dma_active_q;
  assign bus.dma_addr     = dma_addr_q;
  assign bus.dma_rd       = dma_rd_q;
  assign bus.ppu_wdata    = ppu_wdata_q;
  assign bus.ppu_cs_n     = ppu_cs_n_q;
  assign bus.ppu_we       = ppu_we_q;
  assign bus.ppu_reg_addr = OAM_REG;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;
  localparam int CS_LOW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oam_dma_if bus();

  oam_dma #(.DMA_REG(16'h4014), .OAM_REG(3'd4), .CS_LOW(CS_LOW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // CPU memory: page $FF holds ~low byte, every other page holds the low byte
  assign bus.dma_rdata = (bus.dma_addr[15:8] == 8'hFF) ? ~bus.dma_addr[7:0] : bus.dma_addr[7:0];

  int nvec = 0;
  int nerr = 0;

  // cpu_ce: one clk in three, changed just after the rising edge
  int ce_div = 0;
  initial begin
    bus.cpu_ce = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ce_div = (ce_div == 2) ? 0 : ce_div + 1;
      bus.cpu_ce = (ce_div == 0);
    end
  end

  // CPU cycles since reset release; its low bit is the expected DUT parity
  int ce_seen;
  always @(posedge clk or posedge reset) begin
    if (reset) ce_seen <= 0;
    else if (bus.cpu_ce) ce_seen <= ce_seen + 1;
  end

  // bus monitor, sampled on the falling edge
  int          low_n, rd_n, wr_n, cs_bad, run;
  logic        prev_cs = 1'b1;
  logic [15:0] rd_addr [256];
  logic [7:0]  wr_data [256];
  initial begin
    low_n = 0; rd_n = 0; wr_n = 0; cs_bad = 0; run = 0;
  end
  always @(negedge clk) begin
    if (bus.cpu_ce && !bus.cpu_rdy) low_n++;
    if (bus.cpu_ce && bus.dma_rd) begin
      if (rd_n < 256) rd_addr[rd_n] = bus.dma_addr;
      rd_n++;
    end
    if (!bus.ppu_cs_n) begin
      if (prev_cs) begin
        if (wr_n < 256) wr_data[wr_n] = bus.ppu_wdata;
        wr_n++;
        run = 0;
      end
      run++;
      if (!bus.ppu_we || bus.ppu_reg_addr != 3'd4 || !bus.dma_active) cs_bad++;
    end else begin
      if (!prev_cs && run != CS_LOW) cs_bad++;
      if (bus.ppu_we) cs_bad++;
    end
    prev_cs = bus.ppu_cs_n;
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    low_n = 0; rd_n = 0; wr_n = 0; cs_bad = 0;
  endtask

  task automatic wait_ce();
    @(posedge clk);
    while (bus.cpu_ce !== 1'b1) @(posedge clk);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    wait_ce(); #1;
    bus.cpu_addr = addr; bus.cpu_data = data; bus.cpu_we = 1'b1;
    wait_ce(); #1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
  endtask

  // trigger a transfer on a CPU cycle whose parity is par
  task automatic start_xfer(input logic [7:0] page, input bit par);
    wait_ce(); #1;
    if ((ce_seen % 2) != int'(par)) begin
      wait_ce(); #1;
    end
    clr_mon();
    bus.cpu_addr = 16'h4014; bus.cpu_data = page; bus.cpu_we = 1'b1;
    wait_ce(); #1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.cpu_rdy !== 1'b1 && n < 2500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, (n >= 2500) ? 1 : 0, 0);
    repeat (6) @(negedge clk);
  endtask

  task automatic check_xfer(input string name, input logic [7:0] page,
                            input logic [7:0] mask, input int exp_low);
    int abad, dbad;
    abad = 0; dbad = 0;
    chk({name, "_stall_cycles"}, low_n, exp_low);
    chk({name, "_reads"}, rd_n, 256);
    chk({name, "_writes"}, wr_n, 256);
    for (int i = 0; i < 256; i++) begin
      if (rd_addr[i] !== {page, 8'(i)}) abad++;
      if (wr_data[i] !== (8'(i) ^ mask)) dbad++;
    end
    chk({name, "_bad_addrs"}, abad, 0);
    chk({name, "_bad_data"}, dbad, 0);
    chk({name, "_cs_errors"}, cs_bad, 0);
    chk({name, "_rdy_after"}, int'(bus.cpu_rdy), 1);
    chk({name, "_active_after"}, int'(bus.dma_active), 0);
    chk({name, "_cs_n_after"}, int'(bus.ppu_cs_n), 1);
  endtask

  typedef struct {
    string      name;
    logic [7:0] page;
    bit         par;      // parity of the CPU cycle carrying the $4014 write
    logic [7:0] mask;     // expected byte i is i ^ mask
    int         exp_low;  // cpu_ce pulses seen with cpu_rdy low
  } vec_t;

  vec_t vecs[4];

  initial begin
    int n;
    // parity 1 at trigger -> parity 0 after HALT -> straight to READ: 513
    // parity 0 at trigger -> parity 1 after HALT -> ALIGN first: 514
    vecs[0] = '{"p02_even", 8'h02, 1'b1, 8'h00, 513};
    vecs[1] = '{"p02_odd",  8'h02, 1'b0, 8'h00, 514};
    vecs[2] = '{"pFF_even", 8'hFF, 1'b1, 8'hFF, 513};
    vecs[3] = '{"p80_odd",  8'h80, 1'b0, 8'h00, 514};

    reset = 1'b1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cpu_rdy", int'(bus.cpu_rdy), 1);
    chk("rst_dma_active", int'(bus.dma_active), 0);
    chk("rst_dma_rd", int'(bus.dma_rd), 0);
    chk("rst_ppu_cs_n", int'(bus.ppu_cs_n), 1);
    chk("rst_ppu_we", int'(bus.ppu_we), 0);
    chk("rst_dma_addr", int'(bus.dma_addr), 0);
    chk("rst_ppu_wdata", int'(bus.ppu_wdata), 0);
    chk("rst_reg_addr", int'(bus.ppu_reg_addr), 4);
    reset = 1'b0;

    // write to the neighbouring register while idle: nothing happens
    clr_mon();
    cpu_write(16'h4013, 8'h33);
    repeat (5) wait_ce();
    @(negedge clk);
    chk("w4013_rdy", int'(bus.cpu_rdy), 1);
    chk("w4013_active", int'(bus.dma_active), 0);
    chk("w4013_reads", rd_n, 0);

    for (int v = 0; v < 4; v++) begin
      start_xfer(vecs[v].page, vecs[v].par);
      wait_idle(vecs[v].name);
      check_xfer(vecs[v].name, vecs[v].page, vecs[v].mask, vecs[v].exp_low);
    end

    // a second $4014 write mid-transfer must not change page or timing
    start_xfer(8'h02, 1'b1);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (wr_n < 10 && n < 2000);
    chk("inject_reach", (n >= 2000) ? 1 : 0, 0);
    cpu_write(16'h4014, 8'h55);
    wait_idle("inject");
    check_xfer("inject", 8'h02, 8'h00, 513);

    // reset while byte 100 is being written
    start_xfer(8'h02, 1'b1);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (wr_n < 101 && n < 2000);
    chk("abort_reach", (n >= 2000) ? 1 : 0, 0);
    chk("abort_cs_low_before", int'(bus.ppu_cs_n), 0);
    reset = 1'b1;
    #1;
    chk("abort_cpu_rdy", int'(bus.cpu_rdy), 1);
    chk("abort_ppu_cs_n", int'(bus.ppu_cs_n), 1);
    chk("abort_dma_active", int'(bus.dma_active), 0);
    chk("abort_dma_rd", int'(bus.dma_rd), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // fresh transfer after the abort starts again from idx 0
    start_xfer(8'h02, 1'b0);
    wait_idle("restart");
    check_xfer("restart", 8'h02, 8'h00, 514);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
